// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, default
// geometry, the word-index width helper and error cause codes.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } memState_t;

   localparam int DEFAULT_DEPTH_WORDS = 256;

   // Error cause bits; more than one may be set for a single request.
   localparam logic [2:0] ERR_NONE     = 3'b000;
   localparam logic [2:0] ERR_MISALIGN = 3'b001;
   localparam logic [2:0] ERR_RANGE    = 3'b010;
   localparam logic [2:0] ERR_CONFLICT = 3'b100;

   // Number of bits needed to index a word store of the given depth.
   function automatic int idxWidth(input int depthWords);
      return $clog2(depthWords);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU control FSM (master) and the
// memory responder (slave).
interface mem_responder_if #(
   parameter int ADDR_W = 32
) ();

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              mem_ready;
   logic              err;

   modport master (
      output mem_read, mem_write, addr, wdata,
      input  rdata, mem_ready, err
   );

   modport slave (
      input  mem_read, mem_write, addr, wdata,
      output rdata, mem_ready, err
   );

endinterface

// File: rtl/mem_word_array.sv
// Unified instruction/data word store: synchronous write port, combinational
// read port. Contents are deliberately not reset.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int IDX_W       = idxWidth(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] wIdx,
   input  logic [31:0]      wData,
   input  logic [IDX_W-1:0] rIdx,
   output logic [31:0]      rData
);

   logic [31:0] words_r [DEPTH_WORDS];

   // Word write on the clock edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         words_r[wIdx] <= wData;
      end
   end

   assign rData = words_r[rIdx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: captures a read/write
// request, waits WAIT_CYCLES, then answers with a one-cycle mem_ready pulse
// carrying read data or an error flag.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_responder_if.slave  bus
);

   localparam int         IDX_W   = idxWidth(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
   localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

   memState_t         state_r;
   memState_t         nextState_s;
   logic [3:0]        waitCnt_r;
   logic [3:0]        waitCntNext_s;

   logic [ADDR_W-1:0] capAddr_r;
   logic [31:0]       capWdata_r;
   logic              capRead_r;
   logic              capWrite_r;

   logic              memReady_r;
   logic              err_r;
   logic [31:0]       rdata_r;

   logic              reqAny_s;
   logic [ADDR_W-1:0] srcAddr_s;
   logic              srcRead_s;
   logic              srcWrite_s;
   logic [IDX_W-1:0]  srcIdx_s;
   logic [2:0]        errCause_s;
   logic              respErr_s;
   logic [31:0]       respData_s;
   logic              loadResp_s;

   logic              arrWe_s;
   logic [31:0]       arrRdata_s;

   assign reqAny_s = bus.mem_read | bus.mem_write;

   // Request view used for the response: live bus in the capture cycle
   // (needed when there are no wait states), captured copy afterwards.
   always_comb begin
      srcAddr_s  = capAddr_r;
      srcRead_s  = capRead_r;
      srcWrite_s = capWrite_r;
      if (state_r == IDLE) begin
         srcAddr_s  = bus.addr;
         srcRead_s  = bus.mem_read;
         srcWrite_s = bus.mem_write;
      end else begin
         srcAddr_s  = capAddr_r;
         srcRead_s  = capRead_r;
         srcWrite_s = capWrite_r;
      end
   end

   assign srcIdx_s = srcAddr_s[IDX_W+1:2];

   // Classify the request: misaligned, beyond the store, or both strobes set.
   always_comb begin
      errCause_s = ERR_NONE;
      errCause_s = ((srcAddr_s[1:0] != 2'b00)                  ? ERR_MISALIGN : ERR_NONE)
                 | ((srcAddr_s[ADDR_W-1:IDX_W+2] != '0)        ? ERR_RANGE    : ERR_NONE)
                 | ((srcRead_s && srcWrite_s)                  ? ERR_CONFLICT : ERR_NONE);
      respErr_s  = (errCause_s != ERR_NONE);
      respData_s = (respErr_s || !srcRead_s) ? 32'd0 : arrRdata_s;
   end

   // Next-state and wait-counter logic; an abort in BUSY beats completion.
   always_comb begin
      nextState_s   = state_r;
      waitCntNext_s = waitCnt_r;
      case (state_r)
         IDLE: begin
            if (reqAny_s) begin
               if (NO_WAIT) begin
                  nextState_s = RESP;
               end else begin
                  nextState_s   = BUSY;
                  waitCntNext_s = WAIT_LD;
               end
            end else begin
               nextState_s = IDLE;
            end
         end
         BUSY: begin
            if (!reqAny_s) begin
               nextState_s = IDLE;
            end else if (waitCnt_r <= 4'd1) begin
               nextState_s = RESP;
            end else begin
               waitCntNext_s = waitCnt_r - 4'd1;
            end
         end
         RESP: begin
            nextState_s = IDLE;
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   assign loadResp_s = (nextState_s == RESP) && (state_r != RESP);

   // State and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         waitCnt_r <= 4'd0;
      end else begin
         state_r   <= nextState_s;
         waitCnt_r <= waitCntNext_s;
      end
   end

   // Request capture; later changes on the bus are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         capAddr_r  <= '0;
         capWdata_r <= 32'd0;
         capRead_r  <= 1'b0;
         capWrite_r <= 1'b0;
      end else if ((state_r == IDLE) && reqAny_s) begin
         capAddr_r  <= bus.addr;
         capWdata_r <= bus.wdata;
         capRead_r  <= bus.mem_read;
         capWrite_r <= bus.mem_write;
      end
   end

   // Response registers: loaded on entry to RESP, cleared in every other cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memReady_r <= 1'b0;
         err_r      <= 1'b0;
         rdata_r    <= 32'd0;
      end else if (loadResp_s) begin
         memReady_r <= 1'b1;
         err_r      <= respErr_s;
         rdata_r    <= respData_s;
      end else begin
         memReady_r <= 1'b0;
         err_r      <= 1'b0;
         rdata_r    <= 32'd0;
      end
   end

   // Store commits on the edge leaving RESP, only for an error-free write.
   assign arrWe_s = (state_r == RESP) && capWrite_r && !err_r;

   mem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_words (
      .clk   (clk),
      .we    (arrWe_s),
      .wIdx  (capAddr_r[IDX_W+1:2]),
      .wData (capWdata_r),
      .rIdx  (srcIdx_s),
      .rData (arrRdata_s)
   );

   assign bus.mem_ready = memReady_r;
   assign bus.err       = err_r;
   assign bus.rdata     = rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: one instance with two
// wait states and one with none, both checked against a word-array model.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int DEPTH = DEFAULT_DEPTH_WORDS;

   logic clk;
   logic rst_n;

   logic        rdReq [2];
   logic        wrReq [2];
   logic [31:0] addrReq [2];
   logic [31:0] wdReq [2];

   int          waitOf [2] = '{2, 0};
   logic [31:0] model [2][DEPTH];
   bit          known [2][DEPTH];
   bit          inResp [2];

   int checks   = 0;
   int failures = 0;

   mem_responder_if #(.ADDR_W(32)) busA ();
   mem_responder_if #(.ADDR_W(32)) busB ();

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_W(32)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busA)
   );

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busB)
   );

   assign busA.mem_read  = rdReq[0];
   assign busA.mem_write = wrReq[0];
   assign busA.addr      = addrReq[0];
   assign busA.wdata     = wdReq[0];
   assign busB.mem_read  = rdReq[1];
   assign busB.mem_write = wrReq[1];
   assign busB.addr      = addrReq[1];
   assign busB.wdata     = wdReq[1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic readyOf(input int sel);
      return (sel == 1) ? busB.mem_ready : busA.mem_ready;
   endfunction

   function automatic logic errOf(input int sel);
      return (sel == 1) ? busB.err : busA.err;
   endfunction

   function automatic logic [31:0] rdataOf(input int sel);
      return (sel == 1) ? busB.rdata : busA.rdata;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // One complete transaction; keep=1 leaves the strobes up so the next call
   // becomes a back-to-back request.
   task automatic runTxn(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input bit keep);
      int cnt;
      int capAt;
      int expLat;
      int idx;
      bit expErr;
      bit seen;
      capAt  = inResp[sel] ? 2 : 1;
      expLat = waitOf[sel] + capAt;
      idx    = int'(a[9:2]);
      expErr = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4)) || (rd && wr);
      rdReq[sel]   = rd;
      wrReq[sel]   = wr;
      addrReq[sel] = a;
      wdReq[sel]   = d;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (cnt == capAt) begin
            addrReq[sel] = $urandom;
            wdReq[sel]   = $urandom;
         end
         seen = readyOf(sel);
      end
      checkVal("latency", 32'(cnt), 32'(expLat));
      if (seen) begin
         checkVal("err", {31'd0, errOf(sel)}, {31'd0, expErr});
         if (expErr) begin
            checkVal("rdataOnErr", rdataOf(sel), 32'd0);
         end else if (rd && known[sel][idx]) begin
            checkVal("rdata", rdataOf(sel), model[sel][idx]);
         end
         if (!expErr && wr) begin
            model[sel][idx] = d;
            known[sel][idx] = 1'b1;
         end
      end
      if (keep) begin
         inResp[sel] = 1'b1;
      end else begin
         rdReq[sel]  = 1'b0;
         wrReq[sel]  = 1'b0;
         inResp[sel] = 1'b0;
         @(negedge clk);
         checkVal("readyOnePulse", {31'd0, readyOf(sel)}, 32'd0);
      end
   endtask

   // Write on the two-wait instance, dropping the strobes in the first BUSY cycle.
   task automatic abortWrite(input logic [31:0] a, input logic [31:0] d);
      bit seen;
      rdReq[0] = 1'b0; wrReq[0] = 1'b1; addrReq[0] = a; wdReq[0] = d;
      @(negedge clk);
      wrReq[0] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | readyOf(0);
      end
      checkVal("abortNoReady", {31'd0, seen}, 32'd0);
   endtask

   // Write on the two-wait instance, then reset it during BUSY or RESP.
   task automatic resetDuring(input logic [31:0] a, input logic [31:0] d, input bit atResp);
      int cnt;
      rdReq[0] = 1'b0; wrReq[0] = 1'b1; addrReq[0] = a; wdReq[0] = d;
      @(negedge clk);
      cnt = 1;
      while (atResp && !readyOf(0) && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checkVal("readyBeforeReset", {31'd0, readyOf(0)}, {31'd0, atResp});
      #1 rst_n = 1'b0;
      wrReq[0] = 1'b0;
      #1 checkVal("readyAfterReset", {31'd0, readyOf(0)}, 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        rd;
      logic        wr;
      logic [31:0] a;
      int          mode;
      int          sel;
      int          chainLen;

      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         rdReq[s] = 1'b0; wrReq[s] = 1'b0; addrReq[s] = 32'd0; wdReq[s] = 32'd0;
         inResp[s] = 1'b0;
      end
      #3;
      checkVal("rstReadyA", {31'd0, busA.mem_ready}, 32'd0);
      checkVal("rstErrA", {31'd0, busA.err}, 32'd0);
      checkVal("rstRdataA", busA.rdata, 32'd0);
      checkVal("rstReadyB", {31'd0, busB.mem_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Two wait states: write then read back.
      runTxn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      runTxn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

      // No wait states: seed two words, then back-to-back reads.
      runTxn(1, 1'b0, 1'b1, 32'h0, 32'h8C010004, 1'b0);
      runTxn(1, 1'b0, 1'b1, 32'h4, 32'h11112222, 1'b0);
      runTxn(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      runTxn(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);

      // Error responses leave the store untouched.
      runTxn(0, 1'b0, 1'b1, 32'h0, 32'hA5A50000, 1'b0);
      runTxn(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
      runTxn(0, 1'b0, 1'b1, 32'h400, 32'hBADBAD00, 1'b0);
      runTxn(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      runTxn(0, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, 1'b0);
      runTxn(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 1'b0);
      runTxn(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

      // Abort keeps the old word.
      runTxn(0, 1'b0, 1'b1, 32'h20, 32'hCAFE0020, 1'b0);
      abortWrite(32'h20, 32'h12345678);
      runTxn(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

      // Reset mid-BUSY and mid-RESP discards the pending write.
      runTxn(0, 1'b0, 1'b1, 32'h24, 32'hCAFE0024, 1'b0);
      resetDuring(32'h24, 32'h99990024, 1'b0);
      runTxn(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
      runTxn(0, 1'b0, 1'b1, 32'h28, 32'hCAFE0028, 1'b0);
      resetDuring(32'h28, 32'h99990028, 1'b1);
      runTxn(0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0);

      // Randomized traffic, including back-to-back chains.
      for (int n = 0; n < 80; n++) begin
         sel      = int'($urandom_range(0, 1));
         chainLen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1;
         for (int k = 0; k < chainLen; k++) begin
            mode = int'($urandom_range(0, 9));
            rd   = ($urandom_range(0, 1) == 1);
            wr   = !rd;
            a    = {22'd0, 6'($urandom_range(0, 63)), 2'b00};
            case (mode)
               0:       a[1:0] = 2'($urandom_range(1, 3));
               1:       a = 32'h400 + ($urandom & 32'h0000FFFC);
               2:       begin rd = 1'b1; wr = 1'b1; end
               default: a = a;
            endcase
            runTxn(sel, rd, wr, a, $urandom, (k < chainLen - 1));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
